// File: rtl/risc_wb_scheduler_if.sv
// Issue, writeback-request and register-file write bundle for the writeback scheduler.
// The master side is decode/execute; the slave side is the scheduler itself.
interface risc_wb_scheduler_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic [4:0]      issue_rs1;
  logic [4:0]      issue_rs2;
  logic [4:0]      issue_rd;
  logic            issue_stall;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            rf_we;
  logic [4:0]      rf_addr3;
  logic [XLEN-1:0] rf_wd;
  logic [31:0]     busy;
  logic [5:0]      pending_cnt;
  logic            wb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  issue_stall, alu_ready, lsu_ready,
    input  rf_we, rf_addr3, rf_wd, busy, pending_cnt, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output issue_stall, alu_ready, lsu_ready,
    output rf_we, rf_addr3, rf_wd, busy, pending_cnt, wb_err
  );
endinterface

// File: rtl/risc_wb_scheduler.sv
// Register scoreboard with hazard stall, and a round-robin arbiter between the ALU and
// LSU writeback ports that feeds a registered register-file write port.
module risc_wb_scheduler #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rset_lg,
  risc_wb_scheduler_if.slave bus
);

  logic [31:0]     busy_r;
  logic [5:0]      cnt_r;
  logic            wb_err_r;
  logic            rf_we_r;
  logic [4:0]      rf_addr3_r;
  logic [XLEN-1:0] rf_wd_r;
  logic            ptr_lsu_r;

  logic            issue_stall_s;
  logic            issue_fire_s;
  logic            alu_gnt_s;
  logic            lsu_gnt_s;
  logic            wb_hit_s;
  logic            set_s;
  logic            clr_s;
  logic [4:0]      wb_rd_s;
  logic [XLEN-1:0] wb_data_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;
  logic [31:0]     busy_nxt_s;
  logic [5:0]      cnt_nxt_s;
  logic            ptr_nxt_s;

  // Hazard detection, writeback arbitration and scoreboard next state
  always_comb begin
    issue_stall_s = bus.issue_valid &
                    (busy_r[bus.issue_rs1] | busy_r[bus.issue_rs2] | busy_r[bus.issue_rd]);
    issue_fire_s  = bus.issue_valid & ~issue_stall_s;
    alu_gnt_s     = bus.alu_valid & (~bus.lsu_valid | ~ptr_lsu_r);
    lsu_gnt_s     = bus.lsu_valid & (~bus.alu_valid | ptr_lsu_r);
    if (lsu_gnt_s) begin
      wb_rd_s   = bus.lsu_rd;
      wb_data_s = bus.lsu_data;
    end else begin
      wb_rd_s   = bus.alu_rd;
      wb_data_s = bus.alu_data;
    end
    wb_hit_s   = (alu_gnt_s | lsu_gnt_s) & (wb_rd_s != 5'd0);
    set_s      = issue_fire_s & (bus.issue_rd != 5'd0);
    clr_s      = wb_hit_s & busy_r[wb_rd_s];
    set_mask_s = set_s ? (32'd1 << bus.issue_rd) : 32'd0;
    clr_mask_s = clr_s ? (32'd1 << wb_rd_s) : 32'd0;
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    // Saturating count; a set and a clear on one edge always target different registers
    if (set_s && !clr_s && (cnt_r != 6'd31)) begin
      cnt_nxt_s = cnt_r + 6'd1;
    end else if (clr_s && !set_s && (cnt_r != 6'd0)) begin
      cnt_nxt_s = cnt_r - 6'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
    if (bus.alu_valid && bus.lsu_valid) begin
      ptr_nxt_s = alu_gnt_s;
    end else begin
      ptr_nxt_s = ptr_lsu_r;
    end
  end

  // State registers and the registered register-file write port
  always_ff @(posedge clk or negedge rset_lg) begin
    if (!rset_lg) begin
      busy_r     <= 32'd0;
      cnt_r      <= 6'd0;
      wb_err_r   <= 1'b0;
      rf_we_r    <= 1'b0;
      rf_addr3_r <= 5'd0;
      rf_wd_r    <= {XLEN{1'b0}};
      ptr_lsu_r  <= 1'b1;
    end else begin
      busy_r    <= busy_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ptr_lsu_r <= ptr_nxt_s;
      wb_err_r  <= wb_err_r | (wb_hit_s & ~busy_r[wb_rd_s]);
      rf_we_r   <= wb_hit_s;
      if (wb_hit_s) begin
        rf_addr3_r <= wb_rd_s;
        rf_wd_r    <= wb_data_s;
      end else begin
        rf_addr3_r <= rf_addr3_r;
        rf_wd_r    <= rf_wd_r;
      end
    end
  end

  assign bus.issue_stall = issue_stall_s;
  assign bus.alu_ready   = alu_gnt_s;
  assign bus.lsu_ready   = lsu_gnt_s;
  assign bus.rf_we       = rf_we_r;
  assign bus.rf_addr3    = rf_addr3_r;
  assign bus.rf_wd       = rf_wd_r;
  assign bus.busy        = busy_r;
  assign bus.pending_cnt = cnt_r;
  assign bus.wb_err      = wb_err_r;

endmodule

// File: doc/risc_wb_scheduler.md
RISC_WB_SCHEDULER -- requirements
Module: risc_wb_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the register-file write port.
REQ-002 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have rset_lg  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have issue_valid  input  1  decode presents an instruction for issue.
REQ-005 SHALL have issue_rs1, issue_rs2, issue_rd  input  5 each  source and destination register indices.
REQ-006 SHALL have issue_stall  output  1  issue blocked by a register hazard.
REQ-007 SHALL have alu_valid, alu_rd[5], alu_data[XLEN]  input  ALU writeback request.
REQ-008 SHALL have alu_ready  output  1  ALU writeback granted this cycle.
REQ-009 SHALL have lsu_valid, lsu_rd[5], lsu_data[XLEN]  input  load-unit writeback request.
REQ-010 SHALL have lsu_ready  output  1  LSU writeback granted this cycle.
REQ-011 SHALL have rf_we, rf_addr3[5], rf_wd[XLEN]  output  registered register-file write port.
REQ-012 SHALL have busy  output  32  scoreboard, bit n = write to xn pending.
REQ-013 SHALL have pending_cnt  output  6  number of set busy bits.
REQ-014 SHALL have wb_err  output  1  sticky flag, writeback to a non-busy nonzero register.

Function
REQ-015 SHALL drive issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[rd]), combinational; busy[0] is constant 0.
REQ-016 SHALL accept issue when issue_valid & !issue_stall; on that edge set busy[issue_rd] if issue_rd != 0.
REQ-017 SHALL apply no bypass: a register cleared at edge E still stalls issue in the cycle before E.
REQ-018 SHALL grant at most one writeback per cycle; alu_ready/lsu_ready are combinational from the valids and the priority pointer.
REQ-019 SHALL grant the sole valid requester; when both are valid, grant the one favoured by the pointer, then point the pointer at the loser (round-robin).
REQ-020 SHALL leave the pointer unchanged on uncontended grants.
REQ-021 SHALL treat a transfer as valid & ready; requesters hold valid/rd/data stable until ready.
REQ-022 SHALL, on the edge after a grant with rd != 0, drive rf_we=1, rf_addr3=rd, rf_wd=data for exactly one cycle (1-cycle latency).
REQ-023 SHALL clear busy[rd] on the grant edge.
REQ-024 SHALL, for a granted writeback with rd = 0, complete the handshake, keep rf_we=0 and change no busy bit.
REQ-025 SHALL keep rf_we=0 in cycles with no grant, with rf_addr3/rf_wd holding their last values.
REQ-026 SHALL set wb_err on a grant whose rd != 0 has busy[rd]=0; the write still occurs; wb_err clears only on reset.
REQ-027 SHALL update pending_cnt by +1 on a set, -1 on a clear, and net 0 when both occur on one edge for different registers.
REQ-028 SHALL make same-edge set and clear of one register impossible, because REQ-015 stalls issue while busy[rd]=1.
REQ-029 SHALL hold pending_cnt within 0..31 and never wrap.

Reset
REQ-030 SHALL, on rset_lg=0 and independent of clk, immediately clear busy, pending_cnt, wb_err, rf_we, rf_addr3 and rf_wd, and set the pointer to favour LSU.
REQ-031 SHALL discard all pending writes on reset mid-operation; rf_we drops within the reset assertion, before any clock edge.
REQ-032 SHALL resume normal operation on the first rising edge after rset_lg returns to 1.

Verification
REQ-033 Bench SHALL cover issue rd=5, then issue rs1=5 -> second issue stalls until the ALU writeback of x5 is granted; on the edge after that grant, rf_we=1 and rf_addr3=5.
REQ-034 Bench SHALL cover alu_valid and lsu_valid both held for 4 cycles after reset -> grants LSU, ALU, LSU, ALU.
REQ-035 Bench SHALL cover a writeback with rd=0 and data=0xDEADBEEF -> ready asserted, rf_we stays 0, busy unchanged.
REQ-036 Bench SHALL cover a writeback to x7 while busy[7]=0 -> wb_err=1 and stays 1; rf write to x7 occurs.
REQ-037 Bench SHALL cover issue rd=3 and a grant clearing x9 on the same edge, with pending_cnt=1 and x9 busy -> busy[3]=1, busy[9]=0, pending_cnt=1.
REQ-038 Bench SHALL cover asserting rset_lg=0 mid-cycle with 3 busy bits and rf_we=1 -> busy=0, pending_cnt=0 and rf_we=0 before the next clk edge.
